// File: rtl/key_conditioner_pkg.sv
// Shared constants for the key conditioning stage: key indices, per-key FSM encodings and a
// counter-width helper.
package key_conditioner_pkg;

  localparam int unsigned KEY_MODE  = 0;
  localparam int unsigned KEY_RST   = 1;
  localparam int unsigned KEY_ENTER = 3;

  typedef enum logic [1:0] {
    KC_RELEASED  = 2'd0,
    KC_PRESSED   = 2'd1,
    KC_REPEATING = 2'd2
  } kc_state_e;

  // Bits needed to hold values 0 .. max_val-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key bundle between the raw pins and the conditioned strobes. The master drives the pins;
// the conditioner is the slave.
interface key_conditioner_if #(
  parameter int unsigned N_KEYS = 4
);
  logic [N_KEYS-1:0] key_n;
  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] long_press;

  modport master (
    output key_n,
    input  level, press, key_release, long_press
  );

  modport slave (
    input  key_n,
    output level, press, key_release, long_press
  );
endinterface

// File: rtl/key_debounce_one.sv
// One key: 2-flop synchronizer, debounce counter and press/repeat/long-press FSM with
// registered single-cycle strobes.
module key_debounce_one
  import key_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic key_release,
  output logic long_press
);

  localparam int unsigned DbW   = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HoldW = cnt_width(((REPEAT_DELAY + 1) > REPEAT_RATE) ?
                                            (REPEAT_DELAY + 1) : REPEAT_RATE);

  logic             sync1, sync2;
  logic             s;
  logic             deb;
  logic [DbW-1:0]   db_cnt;
  kc_state_e        state;
  logic [HoldW-1:0] hold_cnt;

  assign s = ~sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      deb    <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      if (s == deb) begin
        db_cnt <= '0;
      end else if (db_cnt == DbW'(DEBOUNCE_CYCLES - 1)) begin
        deb    <= s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DbW'(1);
      end
    end
  end

  // level is re-registered here so it moves on the same edge as its press/release strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= KC_RELEASED;
      hold_cnt    <= '0;
      level       <= 1'b0;
      press       <= 1'b0;
      key_release <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      press       <= 1'b0;
      key_release <= 1'b0;
      long_press  <= 1'b0;
      level       <= deb;
      if (level && !deb) begin
        key_release <= 1'b1;
        hold_cnt    <= '0;
        state       <= KC_RELEASED;
      end else begin
        case (state)
          KC_RELEASED: begin
            if (deb) begin
              press    <= 1'b1;
              hold_cnt <= '0;
              state    <= KC_PRESSED;
            end
          end
          KC_PRESSED: begin
            if (hold_cnt == HoldW'(REPEAT_DELAY - 1)) begin
              if (REPEAT_EN) begin
                press    <= 1'b1;
                hold_cnt <= '0;
                state    <= KC_REPEATING;
              end else begin
                long_press <= 1'b1;
                hold_cnt   <= HoldW'(REPEAT_DELAY);
              end
            end else if (hold_cnt != HoldW'(REPEAT_DELAY)) begin
              hold_cnt <= hold_cnt + HoldW'(1);
            end
          end
          KC_REPEATING: begin
            if (hold_cnt == HoldW'(REPEAT_RATE - 1)) begin
              press    <= 1'b1;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + HoldW'(1);
            end
          end
          default: state <= KC_RELEASED;
        endcase
      end
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Conditions N_KEYS raw active-low key pins into debounced levels and single-cycle
// press/release/long-press strobes; each key is handled by an independent instance.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int unsigned       N_KEYS          = 4,
  parameter int unsigned       DEBOUNCE_CYCLES = 500000,
  parameter int unsigned       REPEAT_DELAY    = 25000000,
  parameter int unsigned       REPEAT_RATE     = 5000000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK     = '0
) (
  input logic           clk,
  input logic           rst,
  key_conditioner_if.slave kif
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_one #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_key (
      .clk         (clk),
      .rst         (rst),
      .key_n       (kif.key_n[i]),
      .level       (kif.level[i]),
      .press       (kif.press[i]),
      .key_release (kif.key_release[i]),
      .long_press  (kif.long_press[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Randomised and directed bench for key_conditioner against a timestamp-based reference model
// of debounce latency, repeat schedule and long-press rules.
module tb_key_conditioner;

  localparam int unsigned NK   = 4;
  localparam int unsigned DB   = 4;
  localparam int unsigned RD   = 20;
  localparam int unsigned RR   = 8;
  localparam logic [3:0]  MASK = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_conditioner_if #(.N_KEYS(NK)) kif ();

  key_conditioner #(
    .N_KEYS          (NK),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR),
    .REPEAT_MASK     (MASK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  // Reference model: a level change is accepted once DB consecutive samples disagree with the
  // accepted value; outputs follow 3 edges after the last of those samples.
  logic [NK-1:0] m_db, m_level, e_press, e_rel, e_long;
  int run[NK], pend[NK], t_press[NK];
  int d;
  bit flipped;

  // Observation counters from the DUT outputs.
  int cnt_press = 0, cnt_rel = 0, cnt_long = 0, cnt_both13 = 0, cnt_press_cyc = 0;
  int edge_all = -1;
  int last_press[NK], last_long[NK];

  initial begin
    m_db = '0;
    m_level = '0;
    for (int k = 0; k < NK; k++) begin
      run[k] = 0; pend[k] = 0; t_press[k] = 0; last_press[k] = -1; last_long[k] = -1;
    end
  end

  always @(posedge clk) begin
    edge_n++;
    e_press = '0;
    e_rel   = '0;
    e_long  = '0;
    if (rst) begin
      m_db    = '0;
      m_level = '0;
      for (int k = 0; k < NK; k++) begin
        run[k]  = 0;
        pend[k] = 0;
      end
    end else begin
      for (int k = 0; k < NK; k++) begin
        flipped = 1'b0;
        if (pend[k] > 0) begin
          pend[k]--;
          if (pend[k] == 0) begin
            flipped    = 1'b1;
            m_level[k] = ~m_level[k];
            if (m_level[k]) begin
              e_press[k] = 1'b1;
              t_press[k] = edge_n;
            end else begin
              e_rel[k] = 1'b1;
            end
          end
        end
        if (!flipped && m_level[k]) begin
          d = edge_n - t_press[k];
          if (MASK[k]) begin
            if (d == int'(RD) || (d > int'(RD) && ((d - int'(RD)) % int'(RR)) == 0))
              e_press[k] = 1'b1;
          end else if (d == int'(RD)) begin
            e_long[k] = 1'b1;
          end
        end
        if ((!kif.key_n[k]) != m_db[k]) run[k]++;
        else run[k] = 0;
        if (run[k] == int'(DB)) begin
          m_db[k] = ~m_db[k];
          run[k]  = 0;
          pend[k] = 3;
        end
      end
    end
    #1;
    check("level",      32'(kif.level),       32'(m_level));
    check("press",      32'(kif.press),       32'(e_press));
    check("release",    32'(kif.key_release), 32'(e_rel));
    check("long_press", 32'(kif.long_press),  32'(e_long));
    cnt_press += $countones(kif.press);
    cnt_rel   += $countones(kif.key_release);
    cnt_long  += $countones(kif.long_press);
    if (|kif.press) cnt_press_cyc++;
    if (kif.press == 4'hF) edge_all = edge_n;
    if (kif.press[1] && kif.press[3]) cnt_both13++;
    for (int k = 0; k < NK; k++) begin
      if (kif.press[k]) last_press[k] = edge_n;
      if (kif.long_press[k]) last_long[k] = edge_n;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int e0, sp, sr, sl, sb;
  logic [NK-1:0] kn;
  int remain[NK];

  initial begin
    kif.key_n = 4'b0000;
    // Reset with all keys held, then release reset.
    cycles(3);
    check("rst_outputs", 32'({kif.level, kif.press, kif.key_release, kif.long_press}), 32'h0);
    sp = cnt_press_cyc;
    rst = 1'b0;
    e0  = edge_n;
    cycles(12);
    check("rst_press_all_edge", 32'(edge_all - e0), 32'd7);
    check("rst_press_cycles", 32'(cnt_press_cyc - sp), 32'd1);
    kif.key_n = 4'b1111;
    cycles(15);

    // Bounce on key0, ending held low.
    sp = cnt_press; sr = cnt_rel;
    for (int i = 0; i < 15; i++) begin
      kif.key_n[0] = ~kif.key_n[0];
      cycles(2);
    end
    kif.key_n[0] = 1'b0;
    cycles(12);
    check("bounce_press", 32'(cnt_press - sp), 32'd1);
    check("bounce_release", 32'(cnt_rel - sr), 32'd0);
    kif.key_n[0] = 1'b1;
    cycles(15);

    // Long press on key0.
    sp = cnt_press; sr = cnt_rel; sl = cnt_long;
    kif.key_n[0] = 1'b0;
    cycles(40);
    kif.key_n[0] = 1'b1;
    cycles(15);
    check("long_press_count", 32'(cnt_long - sl), 32'd1);
    check("long_press_press", 32'(cnt_press - sp), 32'd1);
    check("long_press_release", 32'(cnt_rel - sr), 32'd1);
    check("long_press_delay", 32'(last_long[0] - last_press[0]), 32'(RD));

    // Auto-repeat on key3: presses at hold offsets 0,20,28,36,44,52; the one due at 60
    // coincides with release and must be suppressed.
    sp = cnt_press; sr = cnt_rel; sl = cnt_long;
    kif.key_n[3] = 1'b0;
    cycles(60);
    kif.key_n[3] = 1'b1;
    cycles(15);
    check("repeat_press_count", 32'(cnt_press - sp), 32'd6);
    check("repeat_release", 32'(cnt_rel - sr), 32'd1);
    check("repeat_no_long", 32'(cnt_long - sl), 32'd0);

    // Simultaneous key1/key3, key1 released mid-hold of key3.
    sb = cnt_both13;
    kif.key_n[1] = 1'b0;
    kif.key_n[3] = 1'b0;
    cycles(25);
    kif.key_n[1] = 1'b1;
    cycles(30);
    kif.key_n[3] = 1'b1;
    cycles(15);
    check("simul_press_same_edge", 32'(cnt_both13 - sb), 32'd1);

    // Reset while key3 is repeating; key stays held through and after reset.
    kif.key_n[3] = 1'b0;
    cycles(35);
    sr = cnt_rel;
    #2 rst = 1'b1;
    #1;
    check("async_rst_level", 32'(kif.level), 32'h0);
    check("async_rst_strobes", 32'({kif.press, kif.key_release, kif.long_press}), 32'h0);
    cycles(3);
    rst = 1'b0;
    e0  = edge_n;
    cycles(12);
    check("rst_repress_edge", 32'(last_press[3] - e0), 32'd7);
    check("rst_no_release", 32'(cnt_rel - sr), 32'd0);
    kif.key_n[3] = 1'b1;
    cycles(15);

    // Random hold/bounce patterns on all keys.
    kn = kif.key_n;
    for (int k = 0; k < NK; k++) remain[k] = $urandom_range(1, 40);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int k = 0; k < NK; k++) begin
        if (remain[k] == 0) begin
          kn[k]     = ~kn[k];
          remain[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 70);
        end else begin
          remain[k]--;
        end
      end
      kif.key_n = kn;
    end
    kif.key_n = 4'b1111;
    cycles(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
